// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 lock keypad scanner.
// Also provides the helper functions that decode a sampled row pattern.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT,
        RELEASE
    } kp_state_t;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 4;

    localparam logic [NUM_ROWS-1:0] ROWS_IDLE = 4'hF;
    localparam logic [NUM_COLS-1:0] COLS_ALL  = 4'b0000;

    // The lowest-numbered row that is pulled low wins the decode.
    function automatic logic [1:0] lowest_zero(input logic [NUM_ROWS-1:0] rows);
        lowest_zero = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) lowest_zero = 2'(i);
        end
    endfunction

    function automatic logic multi_zero(input logic [NUM_ROWS-1:0] rows);
        int zeros;
        zeros = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) zeros++;
        end
        multi_zero = (zeros > 1);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and lock-FSM-side signals of the column scanner.
// The scanner uses the slave modport; its environment uses master.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] Row;
    logic                S_Row;
    logic [NUM_COLS-1:0] Col;
    logic [KEY_W-1:0]    key_code;
    logic                key_valid;
    logic                scan_miss;
    logic                ghost;

    modport slave (
        input  Row,
        input  S_Row,
        output Col,
        output key_code,
        output key_valid,
        output scan_miss,
        output ghost
    );

    modport master (
        output Row,
        output S_Row,
        input  Col,
        input  key_code,
        input  key_valid,
        input  scan_miss,
        input  ghost
    );

endinterface

// File: rtl/row_sync.sv
// Two-flop synchroniser for the raw keypad rows; resets to "no key" (all ones).
module row_sync
    import keypad_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] raw_row,
    output logic [NUM_ROWS-1:0] sync_row
);

    logic [NUM_ROWS-1:0] meta_row;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_row <= ROWS_IDLE;
            sync_row <= ROWS_IDLE;
        end else begin
            meta_row <= raw_row;
            sync_row <= meta_row;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scan decoder: on a debounced key press, walks the columns low one at a
// time, decodes the first hit into a key code strobe, then waits for release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    keypad_scanner_if.slave   kif
);

    kp_state_t           state;
    logic [1:0]          col_idx;
    logic [CNT_W-1:0]    cnt;
    logic                ghost_pending;
    logic [NUM_ROWS-1:0] row_s;

    row_sync u_row_sync (
        .clock    (clock),
        .reset    (reset),
        .raw_row  (kif.Row),
        .sync_row (row_s)
    );

    // Strobes default low every cycle; Col is registered alongside the state so
    // the drive pattern changes on the same edge as the column index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            col_idx       <= 2'd0;
            cnt           <= '0;
            ghost_pending <= 1'b0;
            kif.Col       <= COLS_ALL;
            kif.key_code  <= '0;
            kif.key_valid <= 1'b0;
            kif.scan_miss <= 1'b0;
            kif.ghost     <= 1'b0;
        end else begin
            kif.key_valid <= 1'b0;
            kif.scan_miss <= 1'b0;
            kif.ghost     <= 1'b0;
            case (state)
                IDLE: begin
                    kif.Col <= COLS_ALL;
                    if (!kif.S_Row) begin
                        state   <= SCAN;
                        col_idx <= 2'd0;
                        cnt     <= '0;
                        kif.Col <= 4'b1110;
                    end
                end
                SCAN: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        if (row_s != ROWS_IDLE) begin
                            kif.key_code  <= {lowest_zero(row_s), col_idx};
                            ghost_pending <= multi_zero(row_s);
                            kif.Col       <= COLS_ALL;
                            state         <= REPORT;
                        end else if (col_idx == 2'd3) begin
                            kif.scan_miss <= 1'b1;
                            kif.Col       <= COLS_ALL;
                            state         <= IDLE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            cnt     <= '0;
                            kif.Col <= ~(4'b0001 << (col_idx + 2'd1));
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPORT: begin
                    kif.key_valid <= 1'b1;
                    kif.ghost     <= ghost_pending;
                    kif.Col       <= COLS_ALL;
                    state         <= RELEASE;
                end
                RELEASE: begin
                    kif.Col <= COLS_ALL;
                    if (kif.S_Row) state <= IDLE;
                end
                default: begin
                    kif.Col <= COLS_ALL;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] pressed;
    int          assertions;
    int          failures;
    int          kvCount;
    int          strobeCount;
    int          kvSnap;
    int          strobeSnap;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SETTLE_CYCLES (16),
        .CNT_W         (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .kif   (kif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        kif.Row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !kif.Col[c]) kif.Row[r] = 1'b0;
            end
        end
    end

    // Running strobe counts so windows can be checked for unexpected pulses.
    always @(negedge clock) begin
        if (kif.key_valid) kvCount <= kvCount + 1;
        if (kif.key_valid || kif.scan_miss || kif.ghost) strobeCount <= strobeCount + 1;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input logic sRow);
        pressed   = keys;
        kif.S_Row = sRow;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        assertions  = 0;
        failures    = 0;
        kvCount     = 0;
        strobeCount = 0;
        reset       = 1'b0;
        applyStimulus(16'h0000, 1'b1);

        #2;
        checkOutput("rst_col",       kif.Col,       4'b0000);
        checkOutput("rst_key_code",  kif.key_code,  4'd0);
        checkOutput("rst_key_valid", {3'b0, kif.key_valid}, 4'd0);
        checkOutput("rst_scan_miss", {3'b0, kif.scan_miss}, 4'd0);
        checkOutput("rst_ghost",     {3'b0, kif.ghost},     4'd0);
        waitCycles(2);
        reset = 1'b1;
        waitCycles(3);

        $display("[TB] key row2/col1");
        applyStimulus(16'h0001 << 9, 1'b0);
        waitCycles(1);
        checkOutput("t1_col0_start", kif.Col, 4'b1110);
        waitCycles(15);
        checkOutput("t1_col0_end", kif.Col, 4'b1110);
        waitCycles(1);
        checkOutput("t1_col1", kif.Col, 4'b1101);
        waitCycles(16);
        checkOutput("t1_report_col", kif.Col, 4'b0000);
        checkOutput("t1_pre_valid", {3'b0, kif.key_valid}, 4'd0);
        waitCycles(1);
        checkOutput("t1_key_valid", {3'b0, kif.key_valid}, 4'd1);
        checkOutput("t1_key_code",  kif.key_code, 4'd9);
        checkOutput("t1_ghost",     {3'b0, kif.ghost}, 4'd0);
        waitCycles(1);
        checkOutput("t1_valid_drop", {3'b0, kif.key_valid}, 4'd0);
        strobeSnap = strobeCount;
        waitCycles(1000);
        checkOutput("t2_hold_strobes", 4'(strobeCount - strobeSnap), 4'd0);
        checkOutput("t2_hold_col", kif.Col, 4'b0000);
        checkOutput("t2_code_held", kif.key_code, 4'd9);
        applyStimulus(16'h0000, 1'b1);
        waitCycles(3);

        $display("[TB] scan with no key");
        kvSnap = kvCount;
        applyStimulus(16'h0000, 1'b0);
        waitCycles(1);
        checkOutput("t3_col0", kif.Col, 4'b1110);
        waitCycles(16);
        checkOutput("t3_col1", kif.Col, 4'b1101);
        waitCycles(16);
        checkOutput("t3_col2", kif.Col, 4'b1011);
        waitCycles(16);
        checkOutput("t3_col3", kif.Col, 4'b0111);
        waitCycles(15);
        checkOutput("t3_pre_miss", {3'b0, kif.scan_miss}, 4'd0);
        waitCycles(1);
        checkOutput("t3_scan_miss", {3'b0, kif.scan_miss}, 4'd1);
        checkOutput("t3_miss_col",  kif.Col, 4'b0000);
        applyStimulus(16'h0000, 1'b1);
        waitCycles(1);
        checkOutput("t3_miss_drop", {3'b0, kif.scan_miss}, 4'd0);
        checkOutput("t3_no_valid", 4'(kvCount - kvSnap), 4'd0);
        waitCycles(3);

        $display("[TB] ghost on col3 rows 1 and 3");
        applyStimulus((16'h0001 << 7) | (16'h0001 << 15), 1'b0);
        waitCycles(65);
        checkOutput("t4_pre_valid", {3'b0, kif.key_valid}, 4'd0);
        waitCycles(1);
        checkOutput("t4_key_valid", {3'b0, kif.key_valid}, 4'd1);
        checkOutput("t4_ghost",     {3'b0, kif.ghost},     4'd1);
        checkOutput("t4_key_code",  kif.key_code, 4'd7);
        waitCycles(1);
        checkOutput("t4_ghost_drop", {3'b0, kif.ghost}, 4'd0);
        applyStimulus(16'h0000, 1'b1);
        waitCycles(3);

        $display("[TB] reset during col2 dwell");
        applyStimulus(16'h0000, 1'b0);
        waitCycles(41);
        checkOutput("t5_col2", kif.Col, 4'b1011);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_col",  kif.Col,      4'b0000);
        checkOutput("t5_rst_code", kif.key_code, 4'd0);
        checkOutput("t5_rst_miss", {3'b0, kif.scan_miss}, 4'd0);
        waitCycles(1);
        applyStimulus(16'h0000, 1'b1);
        reset = 1'b1;
        strobeSnap = strobeCount;
        waitCycles(100);
        checkOutput("t5_no_strobe", 4'(strobeCount - strobeSnap), 4'd0);
        checkOutput("t5_idle_col", kif.Col, 4'b0000);

        $display("[TB] key row0/col0 minimum latency");
        applyStimulus(16'h0001, 1'b0);
        waitCycles(17);
        checkOutput("t6_pre_valid", {3'b0, kif.key_valid}, 4'd0);
        waitCycles(1);
        checkOutput("t6_key_valid", {3'b0, kif.key_valid}, 4'd1);
        checkOutput("t6_key_code",  kif.key_code, 4'd0);
        checkOutput("t6_ghost",     {3'b0, kif.ghost}, 4'd0);
        applyStimulus(16'h0000, 1'b1);
        waitCycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
